// File: rtl/ram_stream_reader.sv
// Sequential RAM reader that streams a frame of words out as an AXI-Stream master.
// A 2-entry skid buffer plus pop-aware read credit sustains one beat per cycle under backpressure.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]  i_length,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_rd_data_valid,
  output logic [DATA_WIDTH-1:0] o_m_axis_tdata,
  output logic                  o_m_axis_tvalid,
  output logic                  o_m_axis_tlast,
  input  logic                  i_m_axis_tready
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  done_q, done_d;
  logic                  inflight_q;

  logic [DATA_WIDTH-1:0] buf_mem_q [2];
  logic [1:0]            buf_cnt_q;
  logic                  wr_ptr_q, rd_ptr_q;

  logic                  push, pop, rd_en;
  logic [2:0]            credit;

  assign push = i_rd_data_valid;
  assign pop  = (buf_cnt_q != 2'd0) && i_m_axis_tready;

  // Words already buffered or in flight, minus the one leaving this cycle.
  assign credit = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en  = (state_q == S_RUN) && (issue_cnt_q != '0) && (credit < 3'd2);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d      = i_base_addr;
          issue_cnt_d = i_length;
          beat_cnt_d  = i_length;
          if (i_length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (rd_en) begin
          addr_d      = addr_q + ADDR_WIDTH'(1);
          issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
        end
        if (pop) begin
          beat_cnt_d = beat_cnt_q - LEN_WIDTH'(1);
          if (beat_cnt_q == LEN_WIDTH'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      done_q      <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      done_q      <= done_d;
      inflight_q  <= rd_en;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          buf_mem_q[gi] <= '0;
        end else if (push && (wr_ptr_q == 1'(gi))) begin
          buf_mem_q[gi] <= i_rd_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      buf_cnt_q <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   buf_cnt_q <= buf_cnt_q + 2'd1;
        2'b01:   buf_cnt_q <= buf_cnt_q - 2'd1;
        default: buf_cnt_q <= buf_cnt_q;
      endcase
    end
  end

  assign o_busy          = (state_q == S_RUN);
  assign o_done          = done_q;
  assign o_rd_en         = rd_en;
  assign o_rd_addr       = addr_q;
  assign o_m_axis_tvalid = (buf_cnt_q != 2'd0);
  assign o_m_axis_tdata  = buf_mem_q[rd_ptr_q];
  assign o_m_axis_tlast  = o_m_axis_tvalid && (beat_cnt_q == LEN_WIDTH'(1));

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed and randomized transfers of ram_stream_reader against a 1-cycle-latency RAM model;
// the expected stream is derived from the frame rules (mem[(base+k) mod 256], k < len).
module tb_ram_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base = 8'h00;
  logic [8:0] len = 9'd0;
  logic       busy, done, rd_en;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] tdata;
  logic       tvalid, tlast;
  logic       tready = 1'b0;

  ram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LEN_WIDTH(9)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base), .i_length(len),
    .o_busy(busy), .o_done(done), .o_rd_en(rd_en), .o_rd_addr(rd_addr),
    .i_rd_data(rd_data), .i_rd_data_valid(rd_valid),
    .o_m_axis_tdata(tdata), .o_m_axis_tvalid(tvalid), .o_m_axis_tlast(tlast),
    .i_m_axis_tready(tready)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total = 0;
  int failed = 0;

  logic [7:0] got_d [$];
  bit         got_l [$];
  int         got_c [$];
  int issued = 0, popped = 0, viol = 0, done_cnt = 0, done_cyc = -1, rden_cnt = 0;

  // Mid-cycle observer: collects handshakes and flags stall/credit violations.
  initial begin
    bit         stall_q;
    logic [7:0] stall_d;
    logic       stall_l;
    bit         p;
    stall_q = 1'b0;
    stall_d = 8'h00;
    stall_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_q = 1'b0;
      end else begin
        p = tvalid && tready;
        if (stall_q && !(tvalid === 1'b1 && tdata === stall_d && tlast === stall_l)) viol++;
        if (issued - popped - int'(p) + int'(rd_en) > 2) viol++;
        if (rd_en) begin
          issued++;
          rden_cnt++;
        end
        if (p) begin
          popped++;
          got_d.push_back(tdata);
          got_l.push_back(tlast);
          got_c.push_back(cyc);
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        stall_q = tvalid && !tready;
        stall_d = tdata;
        stall_l = tlast;
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic drive_ready(input int mode, input int s, input int c);
    if (mode == 1) return 1'($urandom_range(0, 1));
    if (mode == 2) return !(c >= s + 3 && c < s + 8);
    return 1'b1;
  endfunction

  // mode 0: tready high, 1: random tready, 2: tready low for 5 cycles from T+3
  task automatic run(input logic [7:0] b, input int n, input int mode, input bit ign);
    int s, err, lerr, exp_done, first_c, last_c;
    logic [7:0] a;
    got_d.delete();
    got_l.delete();
    got_c.delete();
    viol = 0;
    done_cnt = 0;
    rden_cnt = 0;
    done_cyc = -1;
    s = cyc;
    tready = drive_ready(mode, s, cyc);
    start = 1'b1;
    base = b;
    len = 9'(n);
    step();
    start = 1'b0;
    check("busy_t1", int'(busy), int'(n != 0));
    check("done_t1", int'(done), int'(n == 0));
    for (int k = 0; k < 4 * n + 40 && done_cnt == 0; k++) begin
      tready = drive_ready(mode, s, cyc);
      if (ign && cyc == s + 4) begin
        start = 1'b1;
        base = b + 8'h40;
        len = 9'd2;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    tready = 1'b1;
    check("done_seen", int'(done_cnt != 0), 1);
    step();
    step();
    check("done_pulse", done_cnt, 1);
    check("idle_busy", int'(busy), 0);
    err = 0;
    lerr = 0;
    for (int k = 0; k < got_d.size(); k++) begin
      a = b + 8'(k);
      if (got_d[k] !== mem[a]) err++;
      if (got_l[k] != (k == n - 1)) lerr++;
    end
    check("beats", got_d.size(), n);
    check("data_err", err, 0);
    check("last_err", lerr, 0);
    check("rden_cnt", rden_cnt, n);
    check("violations", viol, 0);
    first_c = (got_c.size() > 0) ? got_c[0] : -1;
    last_c  = (got_c.size() > 0) ? got_c[got_c.size() - 1] : -1;
    exp_done = (n == 0) ? s + 1 : last_c + 1;
    check("done_cyc", done_cyc, exp_done);
    if (mode == 0 && n > 0) begin
      check("first_beat", first_c, s + 3);
      check("burst_span", last_c - first_c, n - 1);
    end
    $display("xfer base=%02h len=%0d mode=%0d ign=%0d beats=%0d first=%0d done=%0d",
             b, n, mode, ign, got_d.size(), first_c - s, done_cyc - s);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    step();
    step();
    check("reset_outs", int'({busy, done, rd_en, rd_addr, tdata, tvalid, tlast}), 0);
    rst = 1'b0;
    step();

    // Reset in the middle of a transfer, then a fresh transfer.
    tready = 1'b0;
    start = 1'b1;
    base = 8'h30;
    len = 9'd8;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("pre_rst_busy", int'(busy), 1);
    check("pre_rst_tvalid", int'(tvalid), 1);
    #2 rst = 1'b1;
    #1 check("rst_async_outs", int'({busy, done, rd_en, rd_addr, tdata, tvalid, tlast}), 0);
    step();
    step();
    rst = 1'b0;
    issued = 0;
    popped = 0;
    step();
    $display("xfer reset mid-transfer base=30 len=8");
    run(8'h20, 5, 0, 1'b0);

    run(8'h10, 4, 0, 1'b0);
    run(8'hFE, 4, 0, 1'b0);

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    run(8'($urandom), 8, 1, 1'b0);
    run(8'($urandom), 8, 2, 1'b0);
    run(8'h55, 0, 0, 1'b0);
    run(8'h80, 6, 0, 1'b1);
    run(8'h00, 256, 0, 1'b0);
    run(8'hC0, 300, 1, 1'b0);
    for (int t = 0; t < 6; t++) begin
      run(8'($urandom), int'($urandom_range(1, 20)), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
